// File: rtl/audio_pkg.sv
// Shared types and default sizing for the audio clip record/playback path.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2,
    FINISH = 2'd3
  } mc_state_t;

  localparam int CLIP_WORDS_DEFAULT = 48000;
  localparam int NUM_CLIPS_DEFAULT  = 4;

endpackage

// File: rtl/clip_addr_counter.sv
// Word-address counter for the active clip bank, with a terminal-address compare.
module clip_addr_counter #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  inc_i,
  input  logic [ADDR_WIDTH-1:0] terminal_i,
  output logic [ADDR_WIDTH-1:0] count_o,
  output logic                  terminal_o
);

  logic [ADDR_WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + ADDR_WIDTH'(1);
    end
  end

  assign count_o    = count_q;
  assign terminal_o = (count_q == terminal_i);

endmodule

// File: rtl/multi_clip_controller.sv
// Record/playback sequencer for NUM_CLIPS clip banks: per-word handshakes,
// per-clip recorded length and a valid bit per clip.
module multi_clip_controller
  import audio_pkg::*;
#(
  parameter int NUM_CLIPS  = NUM_CLIPS_DEFAULT,
  parameter int CLIP_WORDS = CLIP_WORDS_DEFAULT,
  parameter int ADDR_WIDTH = 16,
  parameter int SEL_WIDTH  = $clog2(NUM_CLIPS)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [SEL_WIDTH-1:0]  clip_select_i,
  input  logic                  play_i,
  input  logic                  record_i,
  input  logic                  stop_i,
  output logic                  ser_enable_o,
  input  logic                  ser_word_valid_i,
  output logic                  deser_enable_o,
  input  logic                  deser_word_req_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [NUM_CLIPS-1:0]  mem_en_o,
  output logic [SEL_WIDTH-1:0]  active_clip_o,
  output logic                  playing_o,
  output logic                  recording_o,
  output logic [NUM_CLIPS-1:0]  clip_valid_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam logic [ADDR_WIDTH-1:0] REC_LAST = ADDR_WIDTH'(CLIP_WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   FULL_LEN = (ADDR_WIDTH + 1)'(CLIP_WORDS);

  mc_state_t             state_q;
  logic [SEL_WIDTH-1:0]  clip_q;
  logic [ADDR_WIDTH:0]   len_q [NUM_CLIPS];
  logic [NUM_CLIPS-1:0]  valid_q;
  logic [ADDR_WIDTH:0]   pend_len_q;
  logic                  from_record_q;
  logic                  error_q;

  logic                  play_go;
  logic                  record_go;
  logic                  wr_xfer;
  logic                  rd_xfer;
  logic [ADDR_WIDTH-1:0] play_last;
  logic [ADDR_WIDTH-1:0] term_addr;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  at_term;

  // Handshake: a word moves in exactly the cycle its valid/req is high while
  // the matching state is active; a coincident stop_i suppresses the transfer.
  assign play_go   = (state_q == IDLE) && play_i && valid_q[clip_select_i];
  assign record_go = (state_q == IDLE) && record_i && !play_i;
  assign wr_xfer   = (state_q == RECORD) && ser_word_valid_i && !stop_i;
  assign rd_xfer   = (state_q == PLAY) && deser_word_req_i && !stop_i;

  assign play_last = ADDR_WIDTH'(len_q[clip_q] - 1'b1);
  assign term_addr = (state_q == RECORD) ? REC_LAST : play_last;

  clip_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .clear_i    (play_go || record_go),
    .inc_i      (wr_xfer || rd_xfer),
    .terminal_i (term_addr),
    .count_o    (addr),
    .terminal_o (at_term)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      clip_q        <= '0;
      valid_q       <= '0;
      pend_len_q    <= '0;
      from_record_q <= 1'b0;
      error_q       <= 1'b0;
      for (int i = 0; i < NUM_CLIPS; i++) len_q[i] <= '0;
    end else begin
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (play_i) begin
            clip_q <= clip_select_i;
            if (valid_q[clip_select_i]) begin
              state_q       <= PLAY;
              from_record_q <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
          end else if (record_i) begin
            clip_q        <= clip_select_i;
            state_q       <= RECORD;
            from_record_q <= 1'b1;
          end
        end
        RECORD: begin
          // The address equals the number of words already written.
          if (stop_i) begin
            pend_len_q <= (ADDR_WIDTH + 1)'(addr);
            state_q    <= FINISH;
          end else if (ser_word_valid_i && at_term) begin
            pend_len_q <= FULL_LEN;
            state_q    <= FINISH;
          end
        end
        PLAY: begin
          if (stop_i || (deser_word_req_i && at_term)) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          if (from_record_q) begin
            len_q[clip_q]   <= pend_len_q;
            valid_q[clip_q] <= (pend_len_q != '0);
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en_o       = (wr_xfer || rd_xfer) ?
                          ({{(NUM_CLIPS-1){1'b0}}, 1'b1} << clip_q) : '0;
  assign mem_we_o       = wr_xfer;
  assign mem_addr_o     = addr;
  assign ser_enable_o   = (state_q == RECORD);
  assign recording_o    = (state_q == RECORD);
  assign deser_enable_o = (state_q == PLAY);
  assign playing_o      = (state_q == PLAY);
  assign done_o         = (state_q == FINISH);
  assign error_o        = error_q;
  assign active_clip_o  = clip_q;
  assign clip_valid_o   = valid_q;

endmodule

// File: tb/tb_multi_clip_controller.sv
// Randomized bench for multi_clip_controller: drivers push expected memory,
// done and error events into a queue; a negedge monitor pops and compares.
module tb_multi_clip_controller;

  localparam int NC = 4;
  localparam int CW = 8;
  localparam int AW = 4;
  localparam int SW = 2;
  localparam int EW = 2 + NC + 1 + AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] sel;
  logic          play_i, record_i, stop_i, ser_valid, deser_req;
  logic          ser_enable_o, deser_enable_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [NC-1:0] mem_en_o, clip_valid_o;
  logic [SW-1:0] active_clip_o;
  logic          playing_o, recording_o, done_o, error_o;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int model_len[NC];
  bit model_valid[NC];

  multi_clip_controller #(
    .NUM_CLIPS(NC), .CLIP_WORDS(CW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW)
  ) dut (
    .clock_i          (clk),
    .reset_i          (rst),
    .clip_select_i    (sel),
    .play_i           (play_i),
    .record_i         (record_i),
    .stop_i           (stop_i),
    .ser_enable_o     (ser_enable_o),
    .ser_word_valid_i (ser_valid),
    .deser_enable_o   (deser_enable_o),
    .deser_word_req_i (deser_req),
    .mem_addr_o       (mem_addr_o),
    .mem_we_o         (mem_we_o),
    .mem_en_o         (mem_en_o),
    .active_clip_o    (active_clip_o),
    .playing_o        (playing_o),
    .recording_o      (recording_o),
    .clip_valid_o     (clip_valid_o),
    .done_o           (done_o),
    .error_o          (error_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] ev(input logic [1:0] kind, input logic [NC-1:0] en,
                                       input logic we, input logic [AW-1:0] addr);
    return {kind, en, we, addr};
  endfunction

  function automatic logic [NC-1:0] onehot(input int clip);
    logic [NC-1:0] v;
    v = '0;
    v[clip] = 1'b1;
    return v;
  endfunction

  function automatic logic [NC-1:0] model_vec();
    logic [NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i] = model_valid[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({ser_enable_o, deser_enable_o, mem_en_o, mem_we_o, mem_addr_o, active_clip_o,
                playing_o, recording_o, clip_valid_o, done_o, error_o});
  endfunction

  // Drivers
  task automatic do_record(input int clip, input int n, input bit collide, input int max_gap);
    int nw;
    nw = (n < CW) ? n : CW;
    for (int a = 0; a < nw; a++) exp_q.push_back(ev(2'd1, onehot(clip), 1'b1, AW'(a)));
    exp_q.push_back(ev(2'd2, '0, 1'b0, '0));
    sel = SW'(clip);
    record_i = 1'b1;
    tick();
    record_i = 1'b0;
    check("rec_state", 32'({ser_enable_o, recording_o, deser_enable_o, playing_o}), 32'(4'b1100));
    check("rec_active_clip", 32'(active_clip_o), 32'(clip));
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) tick();
      ser_valid = 1'b1;
      tick();
      ser_valid = 1'b0;
    end
    if (n < CW) begin
      stop_i = 1'b1;
      ser_valid = collide;
      tick();
      stop_i = 1'b0;
      ser_valid = 1'b0;
    end
    repeat (2) tick();
    model_len[clip] = nw;
    model_valid[clip] = (nw != 0);
    check("rec_clip_valid", 32'(clip_valid_o), 32'(model_vec()));
  endtask

  task automatic do_play(input int clip, input int n, input bit collide, input bit also_rec,
                         input int max_gap);
    bit ok;
    int nr;
    ok = model_valid[clip];
    nr = (n < model_len[clip]) ? n : model_len[clip];
    if (ok) begin
      for (int a = 0; a < nr; a++) exp_q.push_back(ev(2'd1, onehot(clip), 1'b0, AW'(a)));
      exp_q.push_back(ev(2'd2, '0, 1'b0, '0));
    end else begin
      exp_q.push_back(ev(2'd3, '0, 1'b0, '0));
    end
    sel = SW'(clip);
    play_i = 1'b1;
    record_i = also_rec;
    tick();
    play_i = 1'b0;
    record_i = 1'b0;
    check("play_state", 32'({ser_enable_o, recording_o, deser_enable_o, playing_o}),
          ok ? 32'(4'b0011) : 32'(4'b0000));
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, max_gap)) tick();
        deser_req = 1'b1;
        tick();
        deser_req = 1'b0;
      end
      if (n < model_len[clip]) begin
        stop_i = 1'b1;
        deser_req = collide;
        tick();
        stop_i = 1'b0;
        deser_req = 1'b0;
      end
    end
    repeat (2) tick();
    check("play_clip_valid", 32'(clip_valid_o), 32'(model_vec()));
  endtask

  // Scoreboard monitor
  logic [EW-1:0] obs, expv;
  bit have;
  always @(negedge clk) begin
    if (!rst) begin
      have = 1'b1;
      if (mem_en_o != '0) obs = ev(2'd1, mem_en_o, mem_we_o, mem_addr_o);
      else if (done_o)    obs = ev(2'd2, '0, 1'b0, '0);
      else if (error_o)   obs = ev(2'd3, '0, 1'b0, '0);
      else                have = 1'b0;
      if (have) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got %0h expected none", obs);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            errors++;
            $display("FAIL event_order: got %0h expected %0h", obs, expv);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    sel = '0;
    {play_i, record_i, stop_i, ser_valid, deser_req} = '0;
    for (int i = 0; i < NC; i++) begin
      model_len[i] = 0;
      model_valid[i] = 1'b0;
    end
    #2;
    check("reset_outputs", all_outputs(), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("post_reset_outputs", all_outputs(), 32'd0);

    do_play(0, 3, 1'b0, 1'b0, 0);         // empty clip -> error, stays idle
    do_record(2, 5, 1'b0, 2);             // 5 words then stop
    do_play(2, 8, 1'b0, 1'b0, 0);         // continuous req, reads 0..4 only
    do_record(1, 9, 1'b0, 1);             // auto finish at full clip, 9th ignored
    do_play(1, 8, 1'b0, 1'b0, 1);
    do_record(3, 3, 1'b1, 1);             // stop coincides with valid at address 3
    do_play(3, 5, 1'b0, 1'b0, 0);
    do_play(1, 3, 1'b1, 1'b0, 1);         // early stop colliding with req
    do_play(2, 2, 1'b0, 1'b1, 0);         // play beats record in same cycle
    do_play(0, 2, 1'b0, 1'b1, 0);         // play of empty clip with record: neither starts
    do_record(0, 0, 1'b0, 0);             // zero-word record keeps clip invalid
    do_record(2, 0, 1'b1, 0);             // zero-word record clears a valid clip
    do_play(2, 2, 1'b0, 1'b0, 0);

    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 1) == 0)
        do_record(int'($urandom_range(0, NC-1)), int'($urandom_range(0, 10)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      else
        do_play(int'($urandom_range(0, NC-1)), int'($urandom_range(0, 9)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    // Reset in the middle of playback
    do_record(2, 5, 1'b0, 0);
    for (int a = 0; a < 2; a++) exp_q.push_back(ev(2'd1, onehot(2), 1'b0, AW'(a)));
    sel = 2'd2;
    play_i = 1'b1;
    tick();
    play_i = 1'b0;
    deser_req = 1'b1;
    repeat (2) tick();
    deser_req = 1'b0;
    check("mid_play_state", 32'(playing_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", all_outputs(), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < NC; i++) begin
      model_len[i] = 0;
      model_valid[i] = 1'b0;
    end
    tick();
    check("after_reset_clip_valid", 32'(clip_valid_o), 32'd0);
    do_play(2, 3, 1'b0, 1'b0, 0);

    repeat (5) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
